credit_vend_controller: RTL and testbench
=========================================

CREDIT_VEND_CONTROLLER -- requirements
Module: credit_vend_controller

Interface
REQ-001 Parameter NUM_PRODUCTS, 4, number of product slots (2..16).
REQ-002 Parameter CREDIT_W, 8, width of credit, coin, price and change values.
REQ-003 Parameter AUTO_CHANGE, 1, 1 = return remaining credit after each vend; 0 = keep credit for further purchases.
REQ-004 Derived PROD_W = max(1, clog2(NUM_PRODUCTS)).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 coin_valid / coin_value  in  1 / CREDIT_W  coin inserted this cycle, its value.
REQ-008 buy / product  in  1 / PROD_W  purchase request, product index.
REQ-009 cancel  in  1  request refund of all credit.
REQ-010 price_we / price_idx / price_data  in  1 / PROD_W / CREDIT_W  price table write port.
REQ-011 change_ack  in  1  consumer has taken change_amount.
REQ-012 vend  out  NUM_PRODUCTS  one-hot, one-cycle dispense pulse.
REQ-013 error / coin_reject  out  1 / 1  one-cycle pulses.
REQ-014 change_valid / change_amount  out  1 / CREDIT_W  refund handshake.
REQ-015 credit  out  CREDIT_W  current credit register; busy  out  1  high when state != IDLE.

Function
REQ-016 FSM SHALL have states IDLE, VEND, CHANGE; all outputs registered.
REQ-017 IDLE priority per cycle SHALL be cancel > buy > coin.
REQ-018 IDLE coin with no buy/cancel SHALL add coin_value to credit, saturating at 2^CREDIT_W-1.
REQ-019 Coin arriving in the same cycle as buy or cancel, or outside IDLE, SHALL be dropped with coin_reject pulsed the next cycle.
REQ-020 buy with product >= NUM_PRODUCTS SHALL pulse error next cycle, credit unchanged, stay IDLE.
REQ-021 buy with credit >= price[product] SHALL, next cycle, pulse vend[product], set credit = credit - price, enter VEND.
REQ-022 buy with credit < price[product] SHALL pulse error next cycle, credit unchanged, stay IDLE.
REQ-023 A zero price SHALL vend with credit unchanged.
REQ-024 VEND SHALL last exactly one cycle, then go to CHANGE if AUTO_CHANGE=1 and credit > 0, else IDLE.
REQ-025 cancel in IDLE with credit > 0 SHALL enter CHANGE; with credit = 0 it SHALL have no effect.
REQ-026 In CHANGE, change_valid SHALL be 1 and change_amount = credit, stable until change_ack.
REQ-027 change_ack while change_valid SHALL clear credit and return to IDLE the next cycle; change_ack at other times SHALL be ignored.
REQ-028 buy outside IDLE SHALL pulse error; cancel outside IDLE SHALL be ignored.
REQ-029 Price writes SHALL be accepted in every state and take effect the next cycle; a buy in the same cycle as a write to its index SHALL use the old price.
REQ-030 Writes with price_idx >= NUM_PRODUCTS SHALL be ignored.

Reset
REQ-031 reset SHALL force IDLE, credit = 0, vend = 0, error = 0, coin_reject = 0, change_valid = 0, change_amount = 0.
REQ-032 reset SHALL load price table from package defaults: slots 0..3 = 75, 20, 30, 40; slots >= 4 = 2^CREDIT_W-1.
REQ-033 reset during CHANGE SHALL drop change_valid immediately and discard credit without refund.
REQ-034 reset SHALL take priority over every other input in the same cycle.

Structure
REQ-035 Shared package vend_pkg SHALL hold the state enum and the default price constants.
REQ-036 The price table SHALL be a sub-module vend_price_table (register array, one write port, one combinational read port).

Verification
REQ-037 Coins 25,25,25 then buy product 0 (price 75), AUTO_CHANGE=1 -> vend=0001 one cycle, credit 0, no CHANGE entry.
REQ-038 Coins 50 then buy product 1 (price 20) -> vend=0010, then change_valid with change_amount 30 held 3 cycles until change_ack, credit 0, IDLE.
REQ-039 Credit 10, buy product 2 (price 30) -> error one cycle, credit stays 10; AUTO_CHANGE=0 credit 60, buy product 3 twice -> second buy errors, credit 20.
REQ-040 Credit 250, coin 10 -> credit 255 (saturated); coin with buy same cycle -> coin_reject, coin not counted.
REQ-041 Write price[1]=5 same cycle as buy product 1 with credit 10 -> charged 20 -> error; next buy charged 5 -> vend.
REQ-042 reset asserted in CHANGE with change_amount 40 -> next cycle change_valid 0, credit 0, prices back to defaults.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and reset-time price defaults for the credit vending controller.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VEND   = 2'd1,
      CHANGE = 2'd2
   } vend_state_e;

   localparam int unsigned NUM_DEFAULT_PRICES = 4;
   localparam int unsigned DEFAULT_PRICE_0    = 75;
   localparam int unsigned DEFAULT_PRICE_1    = 20;
   localparam int unsigned DEFAULT_PRICE_2    = 30;
   localparam int unsigned DEFAULT_PRICE_3    = 40;

   // Slots without an explicit default are priced at the maximum representable credit.
   function automatic longint unsigned default_price(input int unsigned idx,
                                                     input int unsigned credit_w);
      case (idx)
         0:       return 64'(DEFAULT_PRICE_0);
         1:       return 64'(DEFAULT_PRICE_1);
         2:       return 64'(DEFAULT_PRICE_2);
         3:       return 64'(DEFAULT_PRICE_3);
         default: return (64'(1) << credit_w) - 64'(1);
      endcase
   endfunction

endpackage

// File: rtl/vend_price_table.sv
// Price register array: one synchronous write port, one combinational read port.
module vend_price_table
   import vend_pkg::*;
#(
   parameter  int unsigned NUM_PRODUCTS = 4,
   parameter  int unsigned CREDIT_W     = 8,
   localparam int unsigned PROD_W       = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en_i,
   input  logic [PROD_W-1:0]   wr_idx_i,
   input  logic [CREDIT_W-1:0] wr_data_i,
   input  logic [PROD_W-1:0]   rd_idx_i,
   output logic [CREDIT_W-1:0] rd_price_c
);

   logic [CREDIT_W-1:0] price_q [NUM_PRODUCTS];
   logic                wr_ok;
   logic                rd_ok;

   assign wr_ok = 32'(wr_idx_i) < NUM_PRODUCTS;
   assign rd_ok = 32'(rd_idx_i) < NUM_PRODUCTS;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
            price_q[i] <= CREDIT_W'(default_price(i, CREDIT_W));
         end
      end else if (wr_en_i && wr_ok) begin
         price_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Unpopulated indices read as unaffordable.
   assign rd_price_c = rd_ok ? price_q[rd_idx_i] : '1;

endmodule

// File: rtl/credit_vend_controller.sv
// Coin-credit vending controller: accumulates credit, dispenses products, refunds change.
module credit_vend_controller
   import vend_pkg::*;
#(
   parameter  int unsigned NUM_PRODUCTS = 4,
   parameter  int unsigned CREDIT_W     = 8,
   parameter  int unsigned AUTO_CHANGE  = 1,
   localparam int unsigned PROD_W       = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    coin_valid,
   input  logic [CREDIT_W-1:0]     coin_value,
   input  logic                    buy,
   input  logic [PROD_W-1:0]       product,
   input  logic                    cancel,
   input  logic                    price_we,
   input  logic [PROD_W-1:0]       price_idx,
   input  logic [CREDIT_W-1:0]     price_data,
   input  logic                    change_ack,
   output logic [NUM_PRODUCTS-1:0] vend,
   output logic                    error,
   output logic                    coin_reject,
   output logic                    change_valid,
   output logic [CREDIT_W-1:0]     change_amount,
   output logic [CREDIT_W-1:0]     credit,
   output logic                    busy
);

   vend_state_e             state_q, state_d;
   logic [CREDIT_W-1:0]     credit_q, credit_d;
   logic [NUM_PRODUCTS-1:0] vend_q, vend_d;
   logic                    error_q, error_d;
   logic                    coin_reject_q, coin_reject_d;
   logic                    change_valid_q, change_valid_d;
   logic [CREDIT_W-1:0]     change_amount_q, change_amount_d;
   logic                    busy_q, busy_d;

   logic [CREDIT_W-1:0]     price_c;
   logic [CREDIT_W:0]       coin_sum_c;
   logic                    prod_ok_c;

   vend_price_table #(
      .NUM_PRODUCTS (NUM_PRODUCTS),
      .CREDIT_W     (CREDIT_W)
   ) u_price_table (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (price_we),
      .wr_idx_i   (price_idx),
      .wr_data_i  (price_data),
      .rd_idx_i   (product),
      .rd_price_c (price_c)
   );

   assign coin_sum_c = {1'b0, credit_q} + {1'b0, coin_value};
   assign prod_ok_c  = 32'(product) < NUM_PRODUCTS;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         credit_q        <= '0;
         vend_q          <= '0;
         error_q         <= 1'b0;
         coin_reject_q   <= 1'b0;
         change_valid_q  <= 1'b0;
         change_amount_q <= '0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         credit_q        <= credit_d;
         vend_q          <= vend_d;
         error_q         <= error_d;
         coin_reject_q   <= coin_reject_d;
         change_valid_q  <= change_valid_d;
         change_amount_q <= change_amount_d;
         busy_q          <= busy_d;
      end
   end

   // Next-state and registered-output decode; in IDLE cancel beats buy beats coin.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      vend_d        = '0;
      error_d       = 1'b0;
      coin_reject_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (cancel) begin
               coin_reject_d = coin_valid;
               if (credit_q != '0) state_d = CHANGE;
            end else if (buy) begin
               coin_reject_d = coin_valid;
               if (prod_ok_c && (credit_q >= price_c)) begin
                  vend_d   = NUM_PRODUCTS'(1) << product;
                  credit_d = credit_q - price_c;
                  state_d  = VEND;
               end else begin
                  error_d = 1'b1;
               end
            end else if (coin_valid) begin
               credit_d = coin_sum_c[CREDIT_W] ? '1 : coin_sum_c[CREDIT_W-1:0];
            end
         end
         VEND: begin
            error_d       = buy;
            coin_reject_d = coin_valid;
            state_d       = ((AUTO_CHANGE != 0) && (credit_q != '0)) ? CHANGE : IDLE;
         end
         CHANGE: begin
            error_d       = buy;
            coin_reject_d = coin_valid;
            if (change_ack) begin
               credit_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      change_valid_d  = (state_d == CHANGE);
      change_amount_d = change_valid_d ? credit_d : '0;
      busy_d          = (state_d != IDLE);
   end

   assign vend          = vend_q;
   assign error         = error_q;
   assign coin_reject   = coin_reject_q;
   assign change_valid  = change_valid_q;
   assign change_amount = change_amount_q;
   assign credit        = credit_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_credit_vend_controller.sv
// Scenario bench for credit_vend_controller with auto-change and keep-credit instances.
module tb_credit_vend_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       coin_valid;
   logic [7:0] coin_value;
   logic       buy;
   logic [1:0] product;
   logic       cancel;
   logic       price_we;
   logic [1:0] price_idx;
   logic [7:0] price_data;
   logic       change_ack;

   logic [3:0] vend_a, vend_b;
   logic       error_a, error_b, coin_reject_a, coin_reject_b;
   logic       change_valid_a, change_valid_b, busy_a, busy_b;
   logic [7:0] change_amount_a, change_amount_b, credit_a, credit_b;

   int n_cmp = 0;
   int n_bad = 0;

   // {vend, error, coin_reject, change_valid, change_amount, credit, busy}
   typedef logic [23:0] obs_t;

   typedef struct packed {
      logic       rst;
      logic       cv;
      logic [7:0] cval;
      logic       b;
      logic [1:0] p;
      logic       c;
      logic       pwe;
      logic [1:0] pidx;
      logic [7:0] pd;
      logic       ack;
   } stim_t;

   obs_t sb [$];

   always #5 clk = ~clk;

   credit_vend_controller #(.NUM_PRODUCTS(4), .CREDIT_W(8), .AUTO_CHANGE(1)) dut_a (
      .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
      .buy(buy), .product(product), .cancel(cancel), .price_we(price_we),
      .price_idx(price_idx), .price_data(price_data), .change_ack(change_ack),
      .vend(vend_a), .error(error_a), .coin_reject(coin_reject_a),
      .change_valid(change_valid_a), .change_amount(change_amount_a),
      .credit(credit_a), .busy(busy_a)
   );

   credit_vend_controller #(.NUM_PRODUCTS(4), .CREDIT_W(8), .AUTO_CHANGE(0)) dut_b (
      .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
      .buy(buy), .product(product), .cancel(cancel), .price_we(price_we),
      .price_idx(price_idx), .price_data(price_data), .change_ack(change_ack),
      .vend(vend_b), .error(error_b), .coin_reject(coin_reject_b),
      .change_valid(change_valid_b), .change_amount(change_amount_b),
      .credit(credit_b), .busy(busy_b)
   );

   // stim(rst, coin_valid, coin_value, buy, product, cancel, price_we, price_idx, price_data, change_ack)
   function automatic stim_t stim(input logic rst, input logic cv, input logic [7:0] cval,
                                  input logic b, input logic [1:0] p, input logic c,
                                  input logic pwe, input logic [1:0] pidx,
                                  input logic [7:0] pd, input logic ack);
      return {rst, cv, cval, b, p, c, pwe, pidx, pd, ack};
   endfunction

   // obs(vend, error, coin_reject, change_valid, change_amount, credit, busy)
   function automatic obs_t obs(input logic [3:0] v, input logic err, input logic rej,
                                input logic cv, input logic [7:0] ca, input logic [7:0] cr,
                                input logic bsy);
      return {v, err, rej, cv, ca, cr, bsy};
   endfunction

   function automatic obs_t obs_a();
      return {vend_a, error_a, coin_reject_a, change_valid_a, change_amount_a, credit_a, busy_a};
   endfunction

   function automatic obs_t obs_b();
      return {vend_b, error_b, coin_reject_b, change_valid_b, change_amount_b, credit_b, busy_b};
   endfunction

   task automatic drive(input stim_t s);
      reset      = s.rst;
      coin_valid = s.cv;
      coin_value = s.cval;
      buy        = s.b;
      product    = s.p;
      cancel     = s.c;
      price_we   = s.pwe;
      price_idx  = s.pidx;
      price_data = s.pd;
      change_ack = s.ack;
   endtask

   task automatic test_reset();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got_a, got_b, want;
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0, 0, 0, 0));
      st.push_back(stim(1, 1, 25, 1, 0, 1, 1, 0, 9, 1)); ex.push_back(obs(0, 0, 0, 0, 0, 0, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want  = sb.pop_front();
         got_a = obs_a();
         got_b = obs_b();
         n_cmp += 2;
         if (got_a !== want) begin
            n_bad++;
            $display("FAIL test_reset auto step %0d: got %h required %h", i, got_a, want);
         end
         if (got_b !== want) begin
            n_bad++;
            $display("FAIL test_reset keep step %0d: got %h required %h", i, got_b, want);
         end
      end
   endtask

   task automatic test_exact_vend();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0,  0, 0));
      st.push_back(stim(0, 1, 25, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 25, 0));
      st.push_back(stim(0, 1, 25, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 50, 0));
      st.push_back(stim(0, 1, 25, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 75, 0));
      st.push_back(stim(0, 0,  0, 1, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0001, 0, 0, 0, 0,  0, 1));
      st.push_back(stim(0, 1, 10, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 1, 1, 0, 0,  0, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0,  0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_a();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_exact_vend step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_change();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,  0,  0, 0));
      st.push_back(stim(0, 1, 50, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,  0, 50, 0));
      st.push_back(stim(0, 0,  0, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0010, 0, 0, 0,  0, 30, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 1, 30, 30, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 1, 30, 30, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 1, 30, 30, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(4'b0000, 0, 0, 0,  0,  0, 0));
      st.push_back(stim(0, 1,  5, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(4'b0000, 0, 0, 0,  0,  5, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 1,  5,  5, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(4'b0000, 0, 0, 0,  0,  0, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,  0,  0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_a();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_change step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_insufficient();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0,  0,  0, 0));
      st.push_back(stim(0, 1, 10, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0,  0, 10, 0));
      st.push_back(stim(0, 0,  0, 1, 2, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 1, 0, 0,  0, 10, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0,  0, 10, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 1, 10, 10, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(0, 0, 0, 0,  0,  0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_a();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_insufficient step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_keep_credit();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0,  0, 0));
      st.push_back(stim(0, 1, 50, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 50, 0));
      st.push_back(stim(0, 1, 10, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 60, 0));
      st.push_back(stim(0, 0,  0, 1, 3, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b1000, 0, 0, 0, 0, 20, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 20, 0));
      st.push_back(stim(0, 0,  0, 1, 3, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 1, 0, 0, 0, 20, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 20, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_b();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_keep_credit step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_saturate();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,   0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,   0,   0, 0));
      st.push_back(stim(0, 1, 250, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,   0, 250, 0));
      st.push_back(stim(0, 1,  10, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,   0, 255, 0));
      st.push_back(stim(0, 1,   1, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,   0, 255, 0));
      st.push_back(stim(0, 1,   5, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0010, 0, 1, 0,   0, 235, 1));
      st.push_back(stim(0, 0,   0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 1, 235, 235, 1));
      st.push_back(stim(0, 0,   0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(4'b0000, 0, 0, 0,   0,   0, 0));
      st.push_back(stim(0, 1,   7, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,   0,   7, 0));
      st.push_back(stim(0, 1,   3, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 1, 1,   7,   7, 1));
      st.push_back(stim(0, 0,   0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(4'b0000, 0, 0, 0,   0,   0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_a();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_saturate step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_price_write();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0,  0, 0));
      st.push_back(stim(0, 1, 10, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0, 10, 0));
      st.push_back(stim(0, 0,  0, 1, 1, 0, 1, 1, 5, 0)); ex.push_back(obs(4'b0000, 1, 0, 0, 0, 10, 0));
      st.push_back(stim(0, 0,  0, 1, 1, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0010, 0, 0, 0, 0,  5, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 1, 5,  5, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 1, 2, 0, 1)); ex.push_back(obs(4'b0000, 0, 0, 0, 0,  0, 0));
      st.push_back(stim(0, 0,  0, 1, 2, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0100, 0, 0, 0, 0,  0, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0, 0,  0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_a();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_price_write step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_in_change();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0,  0,  0, 0));
      st.push_back(stim(0, 1, 40, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0,  0, 40, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 1, 1, 3, 1, 0)); ex.push_back(obs(0, 0, 0, 1, 40, 40, 1));
      st.push_back(stim(1, 0,  0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0,  0,  0, 0));
      st.push_back(stim(0, 1, 39, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 0,  0, 39, 0));
      st.push_back(stim(0, 0,  0, 1, 3, 0, 0, 0, 0, 0)); ex.push_back(obs(0, 1, 0, 0,  0, 39, 0));
      st.push_back(stim(0, 0,  0, 0, 0, 1, 0, 0, 0, 0)); ex.push_back(obs(0, 0, 0, 1, 39, 39, 1));
      st.push_back(stim(0, 0,  0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(0, 0, 0, 0,  0,  0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_a();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_reset_in_change step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(stim(1, 0,   0, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,  0,   0, 0));
      st.push_back(stim(0, 1, 100, 0, 0, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 0, 0, 0,  0, 100, 0));
      st.push_back(stim(0, 0,   0, 1, 2, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0100, 0, 0, 0,  0,  70, 1));
      st.push_back(stim(0, 0,   0, 1, 2, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 1, 0, 1, 70,  70, 1));
      st.push_back(stim(0, 0,   0, 1, 2, 0, 0, 0, 0, 0)); ex.push_back(obs(4'b0000, 1, 0, 1, 70,  70, 1));
      st.push_back(stim(0, 0,   0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(obs(4'b0000, 0, 0, 0,  0,   0, 0));
      for (int i = 0; i < st.size(); i++) begin
         drive(st[i]);
         sb.push_back(ex[i]);
         @(posedge clk); #1;
         want = sb.pop_front();
         got  = obs_a();
         n_cmp++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL test_back_to_back step %0d: got %h required %h", i, got, want);
         end
      end
   endtask

   initial begin
      drive(stim(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      test_reset();
      test_exact_vend();
      test_change();
      test_insufficient();
      test_keep_credit();
      test_saturate();
      test_price_write();
      test_reset_in_change();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
